// File: rtl/spi_bus_arbiter_pkg.sv
// Shared types and helpers for the SPI lane arbiter.
package spi_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  localparam int WD_W  = 16;
  localparam int GAP_W = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/spi_bus_arbiter_rr_pick.sv
// Round-robin selector: first eligible bit at or above ptr_i, wrapping to bit 0.
module spi_bus_arbiter_rr_pick #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  elig_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  oh_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic found;

  always_comb begin
    oh_o  = '0;
    idx_o = '0;
    found = 1'b0;
    // Upper segment [ptr..N-1] first, then the wrapped segment [0..ptr-1].
    for (int i = 0; i < N; i++) begin
      if (!found && elig_i[i] && (i >= int'(ptr_i))) begin
        found  = 1'b1;
        oh_o[i] = 1'b1;
        idx_o  = IW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && elig_i[i]) begin
        found  = 1'b1;
        oh_o[i] = 1'b1;
        idx_o  = IW'(i);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one SPI lane between pNUM_REQ masters: round-robin grant, turnaround gap,
// and a watchdog that evicts a grantee whose SCK/CS stay frozen.
module spi_bus_arbiter
  import spi_bus_arbiter_pkg::*;
#(
  parameter int pNUM_REQ  = 3,
  parameter int pGAP      = 4,
  parameter int pTIMEOUT  = 65535,
  parameter bit pSCK_IDLE = 1'b0
) (
  input  logic                          clk_usb,
  input  logic                          reset_n,
  input  logic [pNUM_REQ-1:0]           req_i,
  input  logic [pNUM_REQ-1:0]           sck_i,
  input  logic [pNUM_REQ-1:0]           mosi_i,
  input  logic [pNUM_REQ-1:0]           csn_i,
  output logic [pNUM_REQ-1:0]           gnt_o,
  output logic [pNUM_REQ-1:0]           miso_o,
  output logic                          bus_sck_o,
  output logic                          bus_mosi_o,
  output logic [pNUM_REQ-1:0]           bus_csn_o,
  input  logic                          bus_miso_i,
  output logic                          busy_o,
  output logic                          timeout_o,
  output logic [clog2(pNUM_REQ)-1:0]    timeout_src_o,
  input  logic                          timeout_clr_i
);

  localparam int IW = clog2(pNUM_REQ);
  localparam bit WD_EN = (pTIMEOUT > 0);
  localparam logic [WD_W-1:0]  WD_LAST  = (pTIMEOUT > 0) ? WD_W'(pTIMEOUT - 1) : '0;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(pGAP - 1);

  // Async assert, synchronous release of the internal reset.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  state_e                state_q, state_d;
  logic [pNUM_REQ-1:0]   gnt_q, gnt_d;
  logic [pNUM_REQ-1:0]   mask_q, mask_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic                  to_q, to_d;
  logic [IW-1:0]         src_q, src_d;
  logic [pNUM_REQ-1:0]   sck_prev_q, csn_prev_q;

  logic [pNUM_REQ-1:0]   pick_oh;
  logic [IW-1:0]         pick_idx;
  logic                  pick_any;
  logic                  activity;
  logic                  grantee_req;
  logic                  granted;

  spi_bus_arbiter_rr_pick #(.N(pNUM_REQ), .IW(IW)) u_pick (
    .elig_i (req_i & ~mask_q),
    .ptr_i  (ptr_q),
    .oh_o   (pick_oh),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  assign granted     = |gnt_q;
  assign grantee_req = |(gnt_q & req_i);
  assign activity    = |(gnt_q & ((sck_i ^ sck_prev_q) | (csn_i ^ csn_prev_q)));

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    wd_d    = wd_q;
    src_d   = src_q;
    to_d    = to_q & ~timeout_clr_i;
    mask_d  = mask_q & req_i;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_oh;
          idx_d   = pick_idx;
          ptr_d   = (pick_idx == IW'(pNUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
          wd_d    = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!WD_EN || activity) wd_d = '0;
        else if (wd_q != '1)    wd_d = wd_q + 1'b1;
        // A release that coincides with expiry is a normal release.
        if (!grantee_req) begin
          gnt_d   = '0;
          gap_d   = '0;
          state_d = ST_GAP;
        end else if (WD_EN && !activity && (wd_q == WD_LAST)) begin
          gnt_d   = '0;
          gap_d   = '0;
          state_d = ST_GAP;
          to_d    = 1'b1;
          src_d   = idx_q;
          mask_d  = mask_d | gnt_q;
        end
      end
      ST_GAP: begin
        wd_d = '0;
        if (gap_q == GAP_LAST) state_d = ST_IDLE;
        else                   gap_d   = gap_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_usb or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      mask_q     <= '0;
      ptr_q      <= '0;
      idx_q      <= '0;
      gap_q      <= '0;
      wd_q       <= '0;
      to_q       <= 1'b0;
      src_q      <= '0;
      sck_prev_q <= '0;
      csn_prev_q <= '1;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      mask_q     <= mask_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      wd_q       <= wd_d;
      to_q       <= to_d;
      src_q      <= src_d;
      sck_prev_q <= sck_i;
      csn_prev_q <= csn_i;
    end
  end

  // Pad mux is keyed only by the registered grant, so non-grantee CS never leaks.
  assign bus_sck_o     = granted ? |(gnt_q & sck_i) : pSCK_IDLE;
  assign bus_mosi_o    = |(gnt_q & mosi_i);
  assign bus_csn_o     = csn_i | ~gnt_q;
  assign miso_o        = gnt_q & {pNUM_REQ{bus_miso_i}};
  assign gnt_o         = gnt_q;
  assign busy_o        = (state_q != ST_IDLE);
  assign timeout_o     = to_q;
  assign timeout_src_o = src_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Scenario bench for spi_bus_arbiter with a cycle-level reference model.
module tb_spi_bus_arbiter;
  localparam int N   = 3;
  localparam int GAP = 4;
  localparam int TO  = 16;

  logic clk_usb, reset_n;
  logic [N-1:0] req, sck, mosi, csn, gnt, miso, bcsn;
  logic bsck, bmosi, bmiso, busy, to, clr;
  logic [1:0] src;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_owner, m_gap, m_ptr, m_quiet, m_src;
  bit m_to;
  bit [N-1:0] m_mask, m_psck, m_pcsn;

  spi_bus_arbiter #(.pNUM_REQ(N), .pGAP(GAP), .pTIMEOUT(TO), .pSCK_IDLE(1'b0)) dut (
    .clk_usb(clk_usb), .reset_n(reset_n), .req_i(req), .sck_i(sck), .mosi_i(mosi),
    .csn_i(csn), .gnt_o(gnt), .miso_o(miso), .bus_sck_o(bsck), .bus_mosi_o(bmosi),
    .bus_csn_o(bcsn), .bus_miso_i(bmiso), .busy_o(busy), .timeout_o(to),
    .timeout_src_o(src), .timeout_clr_i(clr)
  );

  initial begin
    clk_usb = 1'b0;
    forever #5 clk_usb = ~clk_usb;
  end

  task automatic model_reset();
    m_owner = -1; m_gap = 0; m_ptr = 0; m_quiet = 0; m_src = 0; m_to = 0;
    m_mask = '0; m_psck = '0; m_pcsn = '1;
  endtask

  // Applies one clock edge of the arbitration rules using the pre-edge inputs.
  task automatic model_update();
    bit act;
    bit [N-1:0] old_mask;
    int w;
    old_mask = m_mask;
    m_mask = m_mask & req;
    if (clr) m_to = 0;
    if (m_owner >= 0) begin
      act = (sck[m_owner] != m_psck[m_owner]) || (csn[m_owner] != m_pcsn[m_owner]);
      if (!req[m_owner]) begin
        m_owner = -1; m_gap = GAP;
      end else if (!act && m_quiet == TO - 1) begin
        m_to = 1; m_src = m_owner; m_mask[m_owner] = 1; m_owner = -1; m_gap = GAP;
      end else m_quiet = act ? 0 : m_quiet + 1;
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (w < 0 && req[j] && !old_mask[j]) w = j;
      end
      if (w >= 0) begin m_owner = w; m_ptr = (w + 1) % N; m_quiet = 0; end
    end
    m_psck = sck; m_pcsn = csn;
  endtask

  task automatic step();
    @(posedge clk_usb);
    #1;
    model_update();
  endtask

  task automatic reset_assert();
    reset_n = 1'b0;
    req = '0; sck = '0; mosi = '0; csn = '1; clr = 1'b0; bmiso = 1'b0;
    model_reset();
  endtask

  task automatic reset_release();
    repeat (2) @(posedge clk_usb);
    #3 reset_n = 1'b1;
    repeat (3) @(posedge clk_usb);
    #1;
  endtask

  task automatic test_reset();
    sck = '1; mosi = '1; csn = '0; bmiso = 1'b1;
    #1;
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt got %b want 000", gnt); end
    checks++; if (bcsn !== 3'b111) begin errors++; $display("FAIL reset_csn got %b want 111", bcsn); end
    checks++; if (bsck !== 1'b0) begin errors++; $display("FAIL reset_sck got %b want 0", bsck); end
    checks++; if (bmosi !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b want 0", bmosi); end
    checks++; if (miso !== 3'b000) begin errors++; $display("FAIL reset_miso got %b want 000", miso); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL reset_to got %b want 0", to); end
    checks++; if (src !== 2'd0) begin errors++; $display("FAIL reset_src got %0d want 0", src); end
    sck = '0; mosi = '0; csn = '1; bmiso = 1'b0;
  endtask

  task automatic test_single();
    req = 3'b001;
    step();
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL single_gnt got %b want 001", gnt); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
    csn[0] = 1'b0; #1;
    checks++; if (bcsn !== 3'b110) begin errors++; $display("FAIL single_csn got %b want 110", bcsn); end
    csn[2] = 1'b0; #1;
    checks++; if (bcsn !== 3'b110) begin errors++; $display("FAIL single_glitch got %b want 110", bcsn); end
    csn[2] = 1'b1; sck[0] = 1'b1; mosi[0] = 1'b1; #1;
    checks++; if ({bsck, bmosi} !== 2'b11) begin errors++; $display("FAIL single_sck_mosi got %b want 11", {bsck, bmosi}); end
    repeat (6) step();
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL single_hold got %b want 001", gnt); end
    req[0] = 1'b0;
    step();
    checks++; if ({gnt, bcsn, bsck} !== 7'b000_111_0) begin errors++; $display("FAIL single_release got %b want 0001110", {gnt, bcsn, bsck}); end
    req[0] = 1'b1; // immediate re-request during the gap
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if ({gnt, bcsn, busy} !== 7'b000_111_1) begin errors++; $display("FAIL single_gap%0d got %b want 0001111", c, {gnt, bcsn, busy}); end
    end
    step();
    checks++; if ({gnt, busy} !== 4'b000_0) begin errors++; $display("FAIL single_idle got %b want 0000", {gnt, busy}); end
    step();
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL single_turnaround got %b want 001", gnt); end
    req = '0; csn = '1; sck = '0; mosi = '0;
    repeat (7) step();
  endtask

  task automatic test_round_robin();
    int zc, t, o;
    reset_assert(); reset_release();
    csn = '0; req = 3'b111; zc = 0;
    for (int g = 0; g < 6; g++) begin
      t = 0;
      while (gnt === '0 && t < 20) begin
        step(); t++;
        if (gnt === '0) zc++;
      end
      checks++;
      if (t >= 20) begin errors++; $display("FAIL rr_wait%0d got timeout want grant", g); end
      o = -1;
      for (int i = 0; i < N; i++) if (gnt[i]) o = i;
      checks++; if (o != g % N) begin errors++; $display("FAIL rr_order%0d got %0d want %0d", g, o, g % N); end
      checks++; if (bcsn !== ~gnt) begin errors++; $display("FAIL rr_csn%0d got %b want %b", g, bcsn, ~gnt); end
      if (g > 0) begin
        checks++; if (zc != GAP + 1) begin errors++; $display("FAIL rr_gap%0d got %0d want %0d", g, zc, GAP + 1); end
      end
      repeat (7) step();
      if (o >= 0) req[o] = 1'b0;
      step();
      checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL rr_release%0d got %b want 000", g, gnt); end
      zc = 1;
      req = 3'b111;
    end
    req = '0; csn = '1;
    repeat (14) step();
  endtask

  task automatic test_late_arrival();
    int t;
    reset_assert(); reset_release();
    req = 3'b001; step();
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL late_first got %b want 001", gnt); end
    repeat (2) step();
    req[2] = 1'b1; step();
    req[1] = 1'b1; step();
    repeat (2) step();
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL late_nopreempt got %b want 001", gnt); end
    req[0] = 1'b0; step(); t = 0;
    while (gnt === '0 && t < 20) begin step(); t++; end
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL late_second got %b want 010", gnt); end
    repeat (3) step();
    req[1] = 1'b0; step(); t = 0;
    while (gnt === '0 && t < 20) begin step(); t++; end
    checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL late_third got %b want 100", gnt); end
    req = '0;
    repeat (7) step();
  endtask

  task automatic test_watchdog();
    int cnt;
    reset_assert(); reset_release();
    csn = 3'b101; step();
    req = 3'b010; step();
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL wd_grant got %b want 010", gnt); end
    cnt = 1;
    while (gnt === 3'b010 && cnt < 40) begin
      step();
      if (gnt === 3'b010) cnt++;
    end
    checks++; if (cnt != TO) begin errors++; $display("FAIL wd_hold got %0d want %0d", cnt, TO); end
    checks++; if ({to, src} !== 3'b1_01) begin errors++; $display("FAIL wd_flag got %b want 101", {to, src}); end
    for (int c = 0; c < 15; c++) begin
      step();
      checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL wd_masked%0d got %b want 000", c, gnt); end
    end
    req[1] = 1'b0; step();
    req[1] = 1'b1; step();
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL wd_regrant got %b want 010", gnt); end
    clr = 1'b1; step(); clr = 1'b0;
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL wd_clear got %b want 0", to); end
    repeat (14) step();
    req[1] = 1'b0; step();
    checks++; if ({gnt, to} !== 4'b000_0) begin errors++; $display("FAIL wd_drop_at_expiry got %b want 0000", {gnt, to}); end
    csn = '1;
    repeat (6) step();
  endtask

  task automatic test_reset_mid();
    int t;
    req = 3'b010; csn = 3'b101; t = 0;
    while (gnt !== 3'b010 && t < 20) begin step(); t++; end
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL rmid_grant got %b want 010", gnt); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({gnt, bcsn, busy} !== 7'b000_111_0) begin errors++; $display("FAIL rmid_async got %b want 0001110", {gnt, bcsn, busy}); end
    reset_assert(); reset_release();
    req = 3'b111; step();
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL rmid_first got %b want 001", gnt); end
    req = '0;
    repeat (7) step();
  endtask

  task automatic test_miso();
    int t;
    req = 3'b100; t = 0;
    while (gnt !== 3'b100 && t < 20) begin step(); t++; end
    for (int c = 0; c < 6; c++) begin
      bmiso = 1'($urandom_range(0, 1)); #1;
      checks++; if (miso !== {bmiso, 2'b00}) begin errors++; $display("FAIL miso%0d got %b want %b", c, miso, {bmiso, 2'b00}); end
      step();
    end
    req = '0; bmiso = 1'b0;
    repeat (7) step();
  endtask

  task automatic test_random();
    logic [N-1:0] e_gnt, e_csn, e_miso;
    logic e_sck, e_mosi, e_busy;
    reset_assert(); reset_release();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      step();
      e_gnt = '0; e_csn = '1; e_miso = '0; e_sck = 1'b0; e_mosi = 1'b0;
      if (m_owner >= 0) begin
        e_gnt[m_owner] = 1'b1; e_csn[m_owner] = csn[m_owner];
        e_sck = sck[m_owner]; e_mosi = mosi[m_owner]; e_miso[m_owner] = bmiso;
      end
      e_busy = (m_owner >= 0) || (m_gap > 0);
      checks++; if (gnt !== e_gnt) begin errors++; $display("FAIL rnd_gnt@%0d got %b want %b", cyc, gnt, e_gnt); end
      checks++; if (bcsn !== e_csn) begin errors++; $display("FAIL rnd_csn@%0d got %b want %b", cyc, bcsn, e_csn); end
      checks++; if ({bsck, bmosi} !== {e_sck, e_mosi}) begin errors++; $display("FAIL rnd_sckmosi@%0d got %b want %b", cyc, {bsck, bmosi}, {e_sck, e_mosi}); end
      checks++; if (miso !== e_miso) begin errors++; $display("FAIL rnd_miso@%0d got %b want %b", cyc, miso, e_miso); end
      checks++; if (busy !== e_busy) begin errors++; $display("FAIL rnd_busy@%0d got %b want %b", cyc, busy, e_busy); end
      checks++; if (to !== m_to) begin errors++; $display("FAIL rnd_to@%0d got %b want %b", cyc, to, m_to); end
      checks++; if (src !== 2'(m_src)) begin errors++; $display("FAIL rnd_src@%0d got %0d want %0d", cyc, src, m_src); end
      for (int i = 0; i < N; i++) begin
        if (m_owner == i) begin
          if ($urandom_range(0, 7) == 0) sck[i] = ~sck[i];
          if ($urandom_range(0, 15) == 0) csn[i] = ~csn[i];
          mosi[i] = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 11) == 0) req[i] = 1'b0;
        end else begin
          if (!req[i] && $urandom_range(0, 4) == 0) req[i] = 1'b1;
          else if (req[i] && $urandom_range(0, 39) == 0) req[i] = 1'b0;
          sck[i]  = 1'($urandom_range(0, 1));
          csn[i]  = 1'($urandom_range(0, 1));
          mosi[i] = 1'($urandom_range(0, 1));
        end
      end
      bmiso = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 29) == 0);
    end
    clr = 1'b0;
  endtask

  initial begin
    reset_assert();
    reset_release();
    test_reset();
    test_single();
    test_round_robin();
    test_late_arrival();
    test_watchdog();
    test_reset_mid();
    test_miso();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
